rc4_key_search_ctrl: RTL and testbench
======================================

// Module: rc4_key_search_ctrl
// PURPOSE
//  Parametrised key-space search controller for the RC4 cracker, generalised from one core to NUM_CORES.
//  Partitions [KEY_MIN..KEY_MAX] across NUM_CORES decrypt cores (each core runs KSA shuffle + decrypt + validity check).
//  Dispatches keys over per-core start/done handshakes and reports the winning key, keys tried and match count.
//  Sits between top-level control (switches/LEDs/HEX) and the array of rc4 decrypt cores.
// PARAMETERS
//  NUM_CORES      4           number of parallel decrypt cores (1..16)
//  KEY_WIDTH      24          secret key width in bits (multiple of 8)
//  KEY_MIN        0           first key searched
//  KEY_MAX        24'h3FFFFF  last key searched inclusive (top 2 bits known zero)
//  STOP_ON_FIRST  1           1: abort all cores on first match; 0: exhaustive search, count every match
// PORTS
//  clk          in   1                   system clock
//  reset_n      in   1                   asynchronous active-low reset
//  start        in   1                   begin search; sampled only in IDLE or DONE
//  busy         out  1                   high in SEARCH and DRAIN
//  done         out  1                   level, high in DONE until next accepted start
//  found        out  1                   at least one key matched
//  found_key    out  KEY_WIDTH           first matching key reported (valid when found)
//  keys_tried   out  KEY_WIDTH+1         count of core_done pulses received this search
//  match_count  out  KEY_WIDTH+1         count of core_done pulses with core_found=1
//  core_start   out  NUM_CORES           1-cycle start pulse per core
//  core_key     out  NUM_CORES*KEY_WIDTH key for core i at [i*KEY_WIDTH +: KEY_WIDTH]; stable from start pulse to done
//  core_abort   out  1                   1-cycle pulse: all cores return to idle, no done is produced
//  core_done    in   NUM_CORES           1-cycle pulse per core: key finished
//  core_found   in   NUM_CORES           valid with core_done[i]: key decrypted to a valid message
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE; all outputs 0; per-core trackers C_IDLE; next_key[i]=0.
//  Top FSM: IDLE -> SEARCH -> (DRAIN) -> DONE -> SEARCH on start.
//   IDLE/DONE, start=1 at cycle T: counters, found, found_key cleared at T+1; state SEARCH; busy=1, done=0;
//     core_start[i]=1 at T+1 with core_key[i]=KEY_MIN+i for every i where KEY_MIN+i <= KEY_MAX; other cores retire.
//   start while busy: ignored.
//  Per-core tracker: C_IDLE, C_RUN, C_RETIRED.
//   core_done[i] at T' in C_RUN: keys_tried+1 at T'+1; match_count+1 if core_found[i].
//   No stop, core_key[i]+NUM_CORES <= KEY_MAX: core_key[i] updated and core_start[i] pulses at T'+1 (1-cycle turnaround).
//   Otherwise: C_RETIRED.
//  Next-key arithmetic is done in KEY_WIDTH+1 bits, so no wrap past 2^KEY_WIDTH-1.
//  core_done on an idle or retired core: ignored and not counted.
//  STOP_ON_FIRST=1, first core_found at T':
//   found=1 and found_key=core key at T'+1; core_abort pulses at T'+1; no further core_start; state DONE at T'+1.
//  STOP_ON_FIRST=0: first match latches found_key and all later matches only increment match_count.
//  Simultaneous done pulses from several cores in one cycle: all counted. If several report found, the lowest index wins found_key.
//  Exhaustion: all trackers C_RETIRED, no match, STOP_ON_FIRST=1 -> DONE with found=0.
//   With STOP_ON_FIRST=0 -> DONE with found as latched.
//   SEARCH enters DRAIN while any core is still C_RUN after last dispatch; DRAIN -> DONE when all retired.
//  KEY_MIN > KEY_MAX: start -> DONE at T+1, keys_tried=0, found=0, no core_start.
//  Reset mid-search: immediate return to IDLE; cores are expected to be reset by the same reset_n.
//  Outputs are registered; no combinational path from core_done/core_found to core_start/core_abort.
// TESTING
//  1. NUM_CORES=4, KEY_MAX=15, no match -> 16 starts (keys 0..15, each exactly once); keys_tried=16, done=1, found=0.
//  2. STOP_ON_FIRST=1, core 2 finds key 0x00000A -> found_key=0x00000A, core_abort one pulse, done next cycle, no later core_start.
//  3. Cores 1 and 3 report found in the same cycle (keys 5, 7) -> found_key=5; keys_tried includes both.
//  4. STOP_ON_FIRST=0, KEY_MAX=31, matches at 3, 20, 29 -> match_count=3, found_key=3, keys_tried=32.
//  5. KEY_WIDTH=8, KEY_MAX=8'hFF, NUM_CORES=3 -> last key dispatched 255, no wrap to 0, keys_tried=256.
//  6. reset_n low mid-SEARCH -> all outputs 0 immediately; start after release restarts at KEY_MIN; start while busy ignored.

Source files
------------

// File: rtl/rc4_key_search_ctrl_if.sv
// Core-array bus between the key search controller and its RC4 decrypt cores.
// The controller holds the master modport; the core array holds the slave modport.
interface rc4_key_search_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24
);
  logic [NUM_CORES-1:0]           core_start;
  logic [NUM_CORES*KEY_WIDTH-1:0] core_key;
  logic                           core_abort;
  logic [NUM_CORES-1:0]           core_done;
  logic [NUM_CORES-1:0]           core_found;

  modport master (
    output core_start,
    output core_key,
    output core_abort,
    input  core_done,
    input  core_found
  );

  modport slave (
    input  core_start,
    input  core_key,
    input  core_abort,
    output core_done,
    output core_found
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// Key-space search controller: interleaves [KEY_MIN..KEY_MAX] over NUM_CORES decrypt cores
// (core i tries KEY_MIN+i, KEY_MIN+i+NUM_CORES, ...) and reports the winning key and statistics.
module rc4_key_search_ctrl #(
  parameter int                   NUM_CORES     = 4,
  parameter int                   KEY_WIDTH     = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MIN       = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX       = KEY_WIDTH'(24'h3FFFFF),
  parameter bit                   STOP_ON_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [KEY_WIDTH-1:0]  found_key,
  output logic [KEY_WIDTH:0]    keys_tried,
  output logic [KEY_WIDTH:0]    match_count,
  rc4_key_search_ctrl_if.master core_bus
);

  localparam int KW1 = KEY_WIDTH + 1;
  localparam int CW  = $clog2(NUM_CORES + 1);

  localparam logic [KW1-1:0] MIN_X = {1'b0, KEY_MIN};
  localparam logic [KW1-1:0] MAX_X = {1'b0, KEY_MAX};
  localparam logic [KW1-1:0] STEP  = KW1'(NUM_CORES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_RUN     = 2'd1;
  localparam logic [1:0] C_RETIRED = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [1:0]           trk_q [NUM_CORES];
  logic [1:0]           trk_d [NUM_CORES];
  logic [KEY_WIDTH-1:0] key_q [NUM_CORES];
  logic [KEY_WIDTH-1:0] key_d [NUM_CORES];
  logic [NUM_CORES-1:0] start_q, start_d;
  logic                 abort_q, abort_d;
  logic                 found_q, found_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [KEY_WIDTH-1:0] found_key_q, found_key_d;
  logic [KW1-1:0]       tried_q, tried_d;
  logic [KW1-1:0]       match_q, match_d;

  logic                 searching;
  logic [NUM_CORES-1:0] done_v;
  logic [NUM_CORES-1:0] hit_v;
  logic [CW-1:0]        done_cnt;
  logic [CW-1:0]        hit_cnt;
  logic                 hit_any;
  logic [KEY_WIDTH-1:0] hit_key;
  logic [NUM_CORES*KEY_WIDTH-1:0] key_bus;

  // Only completions from cores we actually dispatched count; the lowest index wins on ties.
  always_comb begin : completion_decode
    searching = (state_q == S_SEARCH) || (state_q == S_DRAIN);
    done_v    = '0;
    hit_v     = '0;
    done_cnt  = '0;
    hit_cnt   = '0;
    hit_any   = 1'b0;
    hit_key   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_v[i] = searching && (trk_q[i] == C_RUN) && core_bus.core_done[i];
      hit_v[i]  = done_v[i] && core_bus.core_found[i];
      done_cnt  = done_cnt + CW'(done_v[i]);
      hit_cnt   = hit_cnt + CW'(hit_v[i]);
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        hit_any = 1'b1;
        hit_key = key_q[i];
      end
    end
  end

  always_comb begin : next_state_logic
    logic [KW1-1:0] nk;
    logic           any_run;
    logic           more;
    logic           resolve;
    nk          = '0;
    any_run     = 1'b0;
    more        = 1'b0;
    resolve     = 1'b0;
    state_d     = state_q;
    trk_d       = trk_q;
    key_d       = key_q;
    start_d     = '0;
    abort_d     = 1'b0;
    found_d     = found_q;
    found_key_d = found_key_q;
    tried_d     = tried_q;
    match_d     = match_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          tried_d     = '0;
          match_d     = '0;
          found_d     = 1'b0;
          found_key_d = '0;
          for (int i = 0; i < NUM_CORES; i++) begin
            nk = MIN_X + KW1'(i);
            if (nk <= MAX_X) begin
              key_d[i]   = nk[KEY_WIDTH-1:0];
              start_d[i] = 1'b1;
              trk_d[i]   = C_RUN;
            end else begin
              trk_d[i]   = C_RETIRED;
            end
          end
          resolve = 1'b1;
        end
      end

      S_SEARCH, S_DRAIN: begin
        tried_d = tried_q + KW1'(done_cnt);
        match_d = match_q + KW1'(hit_cnt);
        if (hit_any && !found_q) begin
          found_d     = 1'b1;
          found_key_d = hit_key;
        end
        if (STOP_ON_FIRST && hit_any) begin
          abort_d = 1'b1;
          state_d = S_DONE;
          for (int i = 0; i < NUM_CORES; i++) begin
            trk_d[i] = C_IDLE;
          end
        end else begin
          // Extended-width add so the last key never wraps back to zero.
          for (int i = 0; i < NUM_CORES; i++) begin
            if (done_v[i]) begin
              nk = {1'b0, key_q[i]} + STEP;
              if (nk <= MAX_X) begin
                key_d[i]   = nk[KEY_WIDTH-1:0];
                start_d[i] = 1'b1;
              end else begin
                trk_d[i]   = C_RETIRED;
              end
            end
          end
          resolve = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // DRAIN once no running core has another key left to receive.
    if (resolve) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (trk_d[i] == C_RUN) begin
          any_run = 1'b1;
          if (({1'b0, key_d[i]} + STEP) <= MAX_X) begin
            more = 1'b1;
          end
        end
      end
      if (!any_run) begin
        state_d = S_DONE;
      end else if (more) begin
        state_d = S_SEARCH;
      end else begin
        state_d = S_DRAIN;
      end
    end

    busy_d = (state_d == S_SEARCH) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      start_q     <= '0;
      abort_q     <= 1'b0;
      found_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_key_q <= '0;
      tried_q     <= '0;
      match_q     <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        trk_q[i] <= C_IDLE;
        key_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      found_q     <= found_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_key_q <= found_key_d;
      tried_q     <= tried_d;
      match_q     <= match_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        trk_q[i] <= trk_d[i];
        key_q[i] <= key_d[i];
      end
    end
  end

  always_comb begin : key_pack
    key_bus = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      key_bus[i*KEY_WIDTH +: KEY_WIDTH] = key_q[i];
    end
  end

  assign core_bus.core_start = start_q;
  assign core_bus.core_key   = key_bus;
  assign core_bus.core_abort = abort_q;

  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign found_key   = found_key_q;
  assign keys_tried  = tried_q;
  assign match_count = match_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: four configurations share a behavioural core-array model
// and a per-core queue of the keys each core must be handed, in order.
module tb_rc4_key_search_ctrl;

  localparam int ND = 4;
  localparam int NCORE [ND] = '{4, 4, 3, 4};
  localparam int KMIN  [ND] = '{0, 0, 0, 5};
  localparam int KMAX  [ND] = '{15, 31, 255, 4};
  localparam int STOPV [ND] = '{1, 0, 1, 1};

  typedef struct {
    int dut;
    int m0;
    int m1;
    int m2;
    bit exhaust;
    bit exp_found;
    int exp_key;
    int exp_tried;
    int exp_match;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_sig   [ND];
  logic busy_o      [ND];
  logic done_o      [ND];
  logic found_o     [ND];
  int   found_key_o [ND];
  int   tried_o     [ND];
  int   match_o     [ND];
  logic [3:0] c_start [ND];
  int         c_key   [ND][4];
  logic       c_abort [ND];
  logic [3:0] c_done  [ND];
  logic [3:0] c_found [ND];

  int   checks = 0;
  int   errors = 0;
  int   cur_dut = 0;
  int   match_keys [3];
  int   exp_q [4][$];
  int   start_count = 0;
  int   abort_count = 0;
  int   late_starts = 0;
  int   start_base, abort_base, late_base;
  bit   running [ND][4];
  int   run_key [ND][4];
  int   lat     [ND][4];
  vec_t vecs [8];

  always #5 clk = ~clk;

  // ---------------- DUT A: 4 cores, keys 0..15, stop on first
  rc4_key_search_ctrl_if #(.NUM_CORES(4), .KEY_WIDTH(24)) bus_a ();
  logic [23:0] fk_a;
  logic [24:0] kt_a, mc_a;
  rc4_key_search_ctrl #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MIN(24'd0), .KEY_MAX(24'd15),
                        .STOP_ON_FIRST(1'b1)) dut_a (
    .clk(clk), .reset_n(rst_n), .start(start_sig[0]), .busy(busy_o[0]), .done(done_o[0]),
    .found(found_o[0]), .found_key(fk_a), .keys_tried(kt_a), .match_count(mc_a), .core_bus(bus_a));
  assign found_key_o[0] = 32'(fk_a);
  assign tried_o[0]     = 32'(kt_a);
  assign match_o[0]     = 32'(mc_a);
  assign c_start[0]     = bus_a.core_start;
  assign c_abort[0]     = bus_a.core_abort;
  assign bus_a.core_done  = c_done[0];
  assign bus_a.core_found = c_found[0];
  for (genvar c = 0; c < 4; c++) begin : g_key_a
    assign c_key[0][c] = 32'(bus_a.core_key[c*24 +: 24]);
  end

  // ---------------- DUT B: 4 cores, keys 0..31, exhaustive
  rc4_key_search_ctrl_if #(.NUM_CORES(4), .KEY_WIDTH(24)) bus_b ();
  logic [23:0] fk_b;
  logic [24:0] kt_b, mc_b;
  rc4_key_search_ctrl #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MIN(24'd0), .KEY_MAX(24'd31),
                        .STOP_ON_FIRST(1'b0)) dut_b (
    .clk(clk), .reset_n(rst_n), .start(start_sig[1]), .busy(busy_o[1]), .done(done_o[1]),
    .found(found_o[1]), .found_key(fk_b), .keys_tried(kt_b), .match_count(mc_b), .core_bus(bus_b));
  assign found_key_o[1] = 32'(fk_b);
  assign tried_o[1]     = 32'(kt_b);
  assign match_o[1]     = 32'(mc_b);
  assign c_start[1]     = bus_b.core_start;
  assign c_abort[1]     = bus_b.core_abort;
  assign bus_b.core_done  = c_done[1];
  assign bus_b.core_found = c_found[1];
  for (genvar c = 0; c < 4; c++) begin : g_key_b
    assign c_key[1][c] = 32'(bus_b.core_key[c*24 +: 24]);
  end

  // ---------------- DUT C: 3 cores, 8-bit keys, full range 0..255
  rc4_key_search_ctrl_if #(.NUM_CORES(3), .KEY_WIDTH(8)) bus_c ();
  logic [7:0] fk_c;
  logic [8:0] kt_c, mc_c;
  rc4_key_search_ctrl #(.NUM_CORES(3), .KEY_WIDTH(8), .KEY_MIN(8'd0), .KEY_MAX(8'hFF),
                        .STOP_ON_FIRST(1'b1)) dut_c (
    .clk(clk), .reset_n(rst_n), .start(start_sig[2]), .busy(busy_o[2]), .done(done_o[2]),
    .found(found_o[2]), .found_key(fk_c), .keys_tried(kt_c), .match_count(mc_c), .core_bus(bus_c));
  assign found_key_o[2] = 32'(fk_c);
  assign tried_o[2]     = 32'(kt_c);
  assign match_o[2]     = 32'(mc_c);
  assign c_start[2]     = {1'b0, bus_c.core_start};
  assign c_abort[2]     = bus_c.core_abort;
  assign bus_c.core_done  = c_done[2][2:0];
  assign bus_c.core_found = c_found[2][2:0];
  for (genvar c = 0; c < 3; c++) begin : g_key_c
    assign c_key[2][c] = 32'(bus_c.core_key[c*8 +: 8]);
  end
  assign c_key[2][3] = 0;

  // ---------------- DUT D: empty range (KEY_MIN > KEY_MAX)
  rc4_key_search_ctrl_if #(.NUM_CORES(4), .KEY_WIDTH(24)) bus_d ();
  logic [23:0] fk_d;
  logic [24:0] kt_d, mc_d;
  rc4_key_search_ctrl #(.NUM_CORES(4), .KEY_WIDTH(24), .KEY_MIN(24'd5), .KEY_MAX(24'd4),
                        .STOP_ON_FIRST(1'b1)) dut_d (
    .clk(clk), .reset_n(rst_n), .start(start_sig[3]), .busy(busy_o[3]), .done(done_o[3]),
    .found(found_o[3]), .found_key(fk_d), .keys_tried(kt_d), .match_count(mc_d), .core_bus(bus_d));
  assign found_key_o[3] = 32'(fk_d);
  assign tried_o[3]     = 32'(kt_d);
  assign match_o[3]     = 32'(mc_d);
  assign c_start[3]     = bus_d.core_start;
  assign c_abort[3]     = bus_d.core_abort;
  assign bus_d.core_done  = c_done[3];
  assign bus_d.core_found = c_found[3];
  for (genvar c = 0; c < 4; c++) begin : g_key_d
    assign c_key[3][c] = 32'(bus_d.core_key[c*24 +: 24]);
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d, input int k);
    return (d == 0) ? 2 : ((k * 7) % 5);
  endfunction

  function automatic bit is_match(input int d, input int k);
    return (d == cur_dut) && (k == match_keys[0] || k == match_keys[1] || k == match_keys[2]);
  endfunction

  // Core-array model, driven on the falling edge; dispatched keys are checked against exp_q.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < ND; d++) begin
        c_done[d]  = '0;
        c_found[d] = '0;
        for (int c = 0; c < 4; c++) running[d][c] = 1'b0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (c_abort[d]) abort_count++;
        for (int c = 0; c < 4; c++) begin
          c_done[d][c]  = 1'b0;
          c_found[d][c] = 1'b0;
          if (c_abort[d]) begin
            running[d][c] = 1'b0;
          end else if (running[d][c]) begin
            if (lat[d][c] == 0) begin
              c_done[d][c]  = 1'b1;
              c_found[d][c] = is_match(d, run_key[d][c]);
              running[d][c] = 1'b0;
            end else begin
              lat[d][c]--;
            end
          end
          if (c_start[d][c]) begin
            start_count++;
            if (done_o[d]) late_starts++;
            if (d == cur_dut && exp_q[c].size() > 0) begin
              checkOutput($sformatf("dispatch_key_d%0d_c%0d", d, c), c_key[d][c], exp_q[c].pop_front());
            end else begin
              checkOutput($sformatf("unexpected_start_d%0d_c%0d", d, c), 1, 0);
            end
            running[d][c] = 1'b1;
            run_key[d][c] = c_key[d][c];
            lat[d][c]     = lat_of(d, c_key[d][c]);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input vec_t v, input bit extra_start);
    int d;
    d = v.dut;
    cur_dut = d;
    match_keys[0] = v.m0;
    match_keys[1] = v.m1;
    match_keys[2] = v.m2;
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      if (c < NCORE[d]) begin
        for (int k = KMIN[d] + c; k <= KMAX[d]; k += NCORE[d]) exp_q[c].push_back(k);
      end
    end
    start_base = start_count;
    abort_base = abort_count;
    late_base  = late_starts;
    @(negedge clk);
    start_sig[d] = 1'b1;
    @(negedge clk);
    start_sig[d] = 1'b0;
    checkOutput("busy_after_start", busy_o[d], (KMIN[d] <= KMAX[d]) ? 1 : 0);
    if (extra_start) begin
      repeat (3) @(negedge clk);
      checkOutput("busy_before_extra_start", busy_o[d], 1);
      start_sig[d] = 1'b1;
      @(negedge clk);
      start_sig[d] = 1'b0;
    end
  endtask

  task automatic runVector(input vec_t v, input bit extra_start);
    int d;
    int cyc;
    int left;
    d = v.dut;
    applyStimulus(v, extra_start);
    cyc = 0;
    while (!done_o[d] && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_within_budget", (cyc < 5000) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    checkOutput("done_level", done_o[d], 1);
    checkOutput("busy_low", busy_o[d], 0);
    checkOutput("found", found_o[d], v.exp_found ? 1 : 0);
    if (v.exp_found) checkOutput("found_key", found_key_o[d], v.exp_key);
    checkOutput("keys_tried", tried_o[d], v.exp_tried);
    checkOutput("match_count", match_o[d], v.exp_match);
    checkOutput("start_pulses", start_count - start_base, v.exp_tried);
    checkOutput("abort_pulses", abort_count - abort_base, (STOPV[d] == 1 && v.exp_found) ? 1 : 0);
    checkOutput("start_after_done", late_starts - late_base, 0);
    if (v.exhaust) begin
      left = 0;
      for (int c = 0; c < 4; c++) left += exp_q[c].size();
      checkOutput("keys_left_undispatched", left, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{0, -1, -1, -1, 1'b1, 1'b0, 0,  16,  0};
    vecs[1] = '{0, 10, -1, -1, 1'b0, 1'b1, 10, 12,  1};
    vecs[2] = '{0,  5,  7, -1, 1'b0, 1'b1, 5,  8,   2};
    vecs[3] = '{1,  3, 20, 29, 1'b1, 1'b1, 3,  32,  3};
    vecs[4] = '{2, -1, -1, -1, 1'b1, 1'b0, 0,  256, 0};
    vecs[5] = '{0,  0, -1, -1, 1'b0, 1'b1, 0,  4,   1};
    vecs[6] = '{1, -1, -1, -1, 1'b1, 1'b0, 0,  32,  0};
    vecs[7] = '{3, -1, -1, -1, 1'b1, 1'b0, 0,  0,   0};
    match_keys = '{-1, -1, -1};
    for (int d = 0; d < ND; d++) start_sig[d] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy_o[0], 0);
    checkOutput("reset_done", done_o[0], 0);
    checkOutput("reset_core_start", int'(c_start[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_done", done_o[0], 0);
    checkOutput("idle_keys_tried", tried_o[0], 0);

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d on configuration %0d", i, vecs[i].dut);
      runVector(vecs[i], 1'b0);
    end

    $display("[TB] asynchronous reset during a search");
    applyStimulus(vecs[0], 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("busy_pre_reset", busy_o[0], 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_busy", busy_o[0], 0);
    checkOutput("mid_reset_done", done_o[0], 0);
    checkOutput("mid_reset_keys_tried", tried_o[0], 0);
    checkOutput("mid_reset_core_start", int'(c_start[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] restart after reset with a start pulse while busy");
    runVector(vecs[0], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
